// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the fixed-latency memory responder
package mem_responder_pkg;

   localparam int LANES = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   typedef logic [7:0] byte_lanes_t [0:LANES-1];

   // The WAIT counter starts at LATENCY-2, so it only needs to hold 0..LATENCY-2
   function automatic int cnt_w(input int lat);
      return (lat < 3) ? 1 : $clog2(lat - 1);
   endfunction

endpackage

// File: rtl/mem_responder_bank.sv
// mem_responder_bank: one byte lane of storage with synchronous write and registered read
module mem_responder_bank #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [0:2**AW-1];
   logic [7:0] rdata_q;

   // Storage is never cleared; only the read register returns to zero on reset
   always_ff @(posedge clk)
      if (we_i) mem_q[waddr_i] <= wdata_i;

   // Read register updates only when asked, so it holds between responses
   always_ff @(posedge clk)
      if (rst) rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency word memory with req/ready/done handshake (option: MEM_RESPONDER_RANGE_CHECK_EN)
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] mem_addr,
   input  logic        mem_write_en,
   input  byte_lanes_t mem_data_in,
   output byte_lanes_t mem_data_out,
   output logic        resp_done,
   output logic        resp_err
);

   localparam int WA = ADDR_W - 2;
   localparam int CW = cnt_w(LATENCY);

   state_t       state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WA-1:0] addr_q, addr_d, raddr;
   logic          we_q, we_d, err_q, err_d, ff_q, ff_d;
   logic          accept, in_err, rd_en, wr_en, unused_addr;
   byte_lanes_t   wdata_q, wdata_d, rdata;

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
   assign in_err      = |mem_addr[31:ADDR_W];
   assign resp_err    = ff_q && state_q == RESP;
   assign unused_addr = ^mem_addr[1:0];
`else
   assign in_err      = 1'b0;
   assign resp_err    = 1'b0;
   assign unused_addr = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};
`endif

   assign accept    = req_valid && state_q == IDLE;
   assign req_ready = state_q == IDLE;
   assign resp_done = state_q == RESP;
   // With LATENCY==1 the read happens on the accept edge, before the latch is valid
   assign raddr     = (state_q == IDLE) ? mem_addr[ADDR_W-1:2] : addr_q;
   assign rd_en     = state_d == RESP && state_q != RESP && !reset;
   assign wr_en     = state_q == RESP && we_q && !err_q && !reset;

   // Next-state: latch the request in IDLE, count down in WAIT, single RESP cycle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      ff_d    = ff_q;
      case (state_q)
         IDLE: if (accept) begin
            addr_d  = mem_addr[ADDR_W-1:2];
            we_d    = mem_write_en;
            wdata_d = mem_data_in;
            err_d   = in_err;
            cnt_d   = CW'((LATENCY > 1) ? LATENCY - 2 : 0);
            state_d = (LATENCY == 1) ? RESP : WAIT;
         end
         WAIT: begin
            state_d = (cnt_q == '0) ? RESP : WAIT;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (rd_en) ff_d = (state_q == IDLE) ? in_err : err_q;
   end

   // State and latched-request registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '{default: 8'h00};
         err_q   <= 1'b0;
         ff_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      mem_responder_bank #(.AW(WA)) u_bank (
         .clk     (clk),
         .rst     (reset),
         .we_i    (wr_en),
         .waddr_i (addr_q),
         .wdata_i (wdata_q[i]),
         .re_i    (rd_en),
         .raddr_i (raddr),
         .rdata_o (rdata[i])
      );
   end

   // Out-of-range reads present all-ones instead of the wrapped storage word
   always_comb
      for (int j = 0; j < LANES; j++) mem_data_out[j] = ff_q ? 8'hFF : rdata[j];

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder at LATENCY 4 and LATENCY 1
module tb_mem_responder;
   import mem_responder_pkg::*;

   typedef struct {
      logic [31:0] data;
      bit          dc;
      logic        err;
      int          cyc;
      string       name;
   } exp_t;

   logic        clk = 0, reset = 1;
   logic [1:0]  req_valid = '0, req_ready, resp_done, resp_err;
   logic [31:0] mem_addr = '0;
   logic        mem_write_en = 0;
   byte_lanes_t mem_data_in, dout0, dout1;
   int          cyc = 0, pass = 0, total = 0;
   exp_t        sb0[$], sb1[$];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
   localparam bit RC = 1;
`else
   localparam bit RC = 0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.ADDR_W(12), .LATENCY(4)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
      .mem_data_out(dout0), .resp_done(resp_done[0]), .resp_err(resp_err[0]));

   mem_responder #(.ADDR_W(12), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_data_in),
      .mem_data_out(dout1), .resp_done(resp_done[1]), .resp_err(resp_err[1]));

   function automatic logic [31:0] pk(input byte_lanes_t x);
      return {x[0], x[1], x[2], x[3]};
   endfunction

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %h expected %h", n, got, exp);
   endtask

   task automatic cmp(input int k, input bit have, input exp_t e, input logic [31:0] d, input logic err);
      total++;
      if (!have) $display("FAIL dut%0d unexpected resp_done at cycle %0d", k, cyc);
      else if (cyc == e.cyc && err === e.err && (e.dc || d === e.data)) pass++;
      else $display("FAIL dut%0d %s: got data %h err %b cycle %0d expected data %h%s err %b cycle %0d",
                    k, e.name, d, err, cyc, e.data, e.dc ? "(any)" : "", e.err, e.cyc);
   endtask

   // Monitor: pop the oldest expectation whenever a responder completes
   always @(negedge clk) begin
      exp_t e;
      bit   h;
      if (!reset && resp_done[0]) begin
         h = sb0.size() > 0;
         if (h) e = sb0.pop_front();
         cmp(0, h, e, pk(dout0), resp_err[0]);
      end
      if (!reset && resp_done[1]) begin
         h = sb1.size() > 0;
         if (h) e = sb1.pop_front();
         cmp(1, h, e, pk(dout1), resp_err[1]);
      end
   end

   task automatic issue(input int k, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] ed, input bit dc, input logic ee, input bit push,
                        input string n, output int t);
      exp_t e;
      int   g = 0;
      @(negedge clk);
      mem_addr = a;
      mem_write_en = w;
      for (int i = 0; i < 4; i++) mem_data_in[i] = d[31-8*i -: 8];
      req_valid[k] = 1;
      while (!req_ready[k] && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (g == 50) begin
         total++;
         $display("FAIL %s: no accept within 50 cycles", n);
      end
      t = cyc;
      e = '{data: ed, dc: dc, err: ee, cyc: t + (k == 1 ? 1 : 4), name: n};
      if (push && k == 0) sb0.push_back(e);
      if (push && k == 1) sb1.push_back(e);
      @(posedge clk);
      #1 req_valid[k] = 0;
   endtask

   initial begin
      int t, t2;
      mem_data_in = '{default: 8'h00};
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 0;
      @(negedge clk);
      chk("reset req_ready", {31'b0, req_ready[0]}, 1);
      chk("reset resp_done", {31'b0, resp_done[0]}, 0);
      chk("reset resp_err", {31'b0, resp_err[0]}, 0);
      chk("reset data_out", pk(dout0), 32'h0);
      issue(0, 32'h20, 1, 32'h55667788, 0, 1, 0, 1, "init 0x20", t);
      issue(0, 32'h30, 1, 32'h12345678, 0, 1, 0, 1, "init 0x30", t);
      issue(0, 32'h04, 1, 32'hA0A1A2A3, 0, 1, 0, 1, "init 0x04", t);
      issue(0, 32'h10, 1, 32'hDEADBEEF, 0, 1, 0, 1, "write 0x10", t);
      issue(0, 32'h13, 0, 0, 32'hDEADBEEF, 0, 0, 1, "read 0x13", t);
      issue(0, 32'h10, 0, 0, 32'hDEADBEEF, 0, 0, 1, "busy read 0x10", t);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mem_addr = 32'h20;
         mem_write_en = 1;
         for (int j = 0; j < 4; j++) mem_data_in[j] = 8'(8'h11 * (j + 1));
         req_valid[0] = (i < 3);
         chk($sformatf("busy req_ready %0d", i), {31'b0, req_ready[0]}, 0);
      end
      issue(0, 32'h20, 0, 0, 32'h55667788, 0, 0, 1, "read 0x20 after busy", t);
      repeat (5) @(negedge clk);
      issue(0, 32'h30, 1, 32'hAABBCCDD, 0, 1, 0, 0, "aborted write", t);
      @(negedge clk);
      @(negedge clk) reset = 1;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 0;
      chk("post-abort req_ready", {31'b0, req_ready[0]}, 1);
      chk("post-abort data_out", pk(dout0), 32'h0);
      issue(0, 32'h30, 0, 0, 32'h12345678, 0, 0, 1, "read 0x30 after abort", t);
      issue(0, 32'h1004, 1, 32'h01020304, 32'hFFFFFFFF, !RC, RC, 1, "write 0x1004", t);
      issue(0, 32'h04, 0, 0, RC ? 32'hA0A1A2A3 : 32'h01020304, 0, 0, 1, "read 0x04 wrap", t);
      issue(1, 32'h40, 1, 32'hC0C1C2C3, 0, 1, 0, 1, "lat1 write 0x40", t);
      @(negedge clk) chk("lat1 ready T+1", {31'b0, req_ready[1]}, 0);
      @(negedge clk) chk("lat1 ready T+2", {31'b0, req_ready[1]}, 1);
      issue(1, 32'h40, 0, 0, 32'hC0C1C2C3, 0, 0, 1, "lat1 read a", t);
      issue(1, 32'h42, 0, 0, 32'hC0C1C2C3, 0, 0, 1, "lat1 read b", t2);
      chk("lat1 spacing", t2 - t, 2);
      repeat (10) @(negedge clk);
      chk("scoreboard drained", sb0.size() + sb1.size(), 0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
